// File: rtl/chess_layout_tile_streamer.sv
// chess_layout_tile_streamer
// Streams board squares whose byte changed since the last transmitted layout
// to the LCD tile renderer over a valid/ready handshake. The first frame after
// reset sends every square. Byte bit 7 is ignored everywhere.
// Build option: define STATUS_TILE_EN to also track {Player, Checkmate} and
// emit a status tile (TilePiece = 7) after square 63 when it changes.
module chess_layout_tile_streamer #(
    parameter int unsigned CHESS_SQUARES = 64,
    parameter int unsigned SQUARE_WIDTH  = 8,
    parameter int unsigned MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
    input  logic                    OutClock,
    input  logic                    resetApp,
    input  logic [MATRIX_WIDTH-1:0] Layout,
    input  logic                    Player,
    input  logic [1:0]              Checkmate,
    input  logic                    TileReady,
    output logic                    TileValid,
    output logic [5:0]              TileIdx,
    output logic [2:0]              TileX,
    output logic [2:0]              TileY,
    output logic [2:0]              TilePiece,
    output logic                    TileWhite,
    output logic                    TileCursor,
    output logic                    TileLocked,
    output logic                    TileCursorLocked,
    output logic                    FrameDone,
    output logic                    Busy
);

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

    localparam logic [SQUARE_WIDTH-1:0] BYTE_MASK   = {1'b0, {(SQUARE_WIDTH-1){1'b1}}};
    localparam logic [MATRIX_WIDTH-1:0] LAYOUT_MASK = {CHESS_SQUARES{BYTE_MASK}};
    localparam logic [5:0]              LAST_IDX    = 6'(CHESS_SQUARES - 1);

    state_t                  state_q;
    logic [5:0]              idx_q;
    logic [MATRIX_WIDTH-1:0] shadow_q;
    logic [MATRIX_WIDTH-1:0] snap_q;
    logic                    full_q;
    logic                    stat_tile_q;
    logic                    valid_q;
    logic [5:0]              tile_idx_q;
    logic [2:0]              tile_piece_q;
    logic                    tile_white_q;
    logic                    tile_cursor_q;
    logic                    tile_locked_q;
    logic                    tile_clocked_q;
    logic                    done_q;

    logic [SQUARE_WIDTH-1:0] snap_byte;
    logic [SQUARE_WIDTH-1:0] shadow_byte;
    logic                    layout_dirty;
    logic                    square_dirty;
    logic                    status_dirty;  // live status differs from shadow
    logic                    status_due;    // status tile owed at end of scan
    logic [2:0]              status_snap;   // {Checkmate[1], Checkmate[0], Player}

    assign snap_byte    = snap_q[idx_q*SQUARE_WIDTH +: SQUARE_WIDTH];
    assign shadow_byte  = shadow_q[idx_q*SQUARE_WIDTH +: SQUARE_WIDTH];
    assign layout_dirty = ((Layout ^ shadow_q) & LAYOUT_MASK) != '0;
    assign square_dirty = ((snap_byte ^ shadow_byte) & BYTE_MASK) != '0;

`ifdef STATUS_TILE_EN
    logic [2:0] stat_snap_q;
    logic [2:0] stat_shadow_q;

    assign status_dirty = {Checkmate, Player} != stat_shadow_q;
    assign status_due   = full_q || (stat_snap_q != stat_shadow_q);
    assign status_snap  = stat_snap_q;

    // Status snapshot follows the inputs while idle; shadow updates when the status tile is taken
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            stat_snap_q   <= '0;
            stat_shadow_q <= '0;
        end else begin
            if (state_q == IDLE)
                stat_snap_q <= {Checkmate, Player};
            if (state_q == OFFER && valid_q && TileReady && stat_tile_q)
                stat_shadow_q <= stat_snap_q;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{Player, Checkmate};
    assign status_dirty  = 1'b0;
    assign status_due    = 1'b0;
    assign status_snap   = '0;
`endif

    // Frame sequencer: detect change, scan squares, offer changed tiles, signal completion
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            shadow_q       <= '0;
            snap_q         <= '0;
            full_q         <= 1'b1;
            stat_tile_q    <= 1'b0;
            valid_q        <= 1'b0;
            tile_idx_q     <= '0;
            tile_piece_q   <= '0;
            tile_white_q   <= 1'b0;
            tile_cursor_q  <= 1'b0;
            tile_locked_q  <= 1'b0;
            tile_clocked_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (full_q || layout_dirty || status_dirty) begin
                        snap_q  <= Layout;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (full_q || square_dirty) begin
                        tile_idx_q     <= idx_q;
                        tile_piece_q   <= snap_byte[2:0];
                        tile_white_q   <= snap_byte[3];
                        tile_cursor_q  <= snap_byte[4];
                        tile_locked_q  <= snap_byte[5];
                        tile_clocked_q <= snap_byte[6];
                        stat_tile_q    <= 1'b0;
                        valid_q        <= 1'b1;
                        state_q        <= OFFER;
                    end else if (idx_q == LAST_IDX) begin
                        if (status_due) begin
                            tile_idx_q     <= '0;
                            tile_piece_q   <= 3'd7;
                            tile_white_q   <= status_snap[0];
                            tile_cursor_q  <= status_snap[1];
                            tile_locked_q  <= status_snap[2];
                            tile_clocked_q <= 1'b0;
                            stat_tile_q    <= 1'b1;
                            valid_q        <= 1'b1;
                            state_q        <= OFFER;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                OFFER: begin
                    if (valid_q && TileReady) begin
                        valid_q <= 1'b0;
                        if (stat_tile_q) begin
                            stat_tile_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            shadow_q[idx_q*SQUARE_WIDTH +: SQUARE_WIDTH] <= snap_byte;
                            if (idx_q == LAST_IDX) begin
                                if (status_due) begin
                                    tile_idx_q     <= '0;
                                    tile_piece_q   <= 3'd7;
                                    tile_white_q   <= status_snap[0];
                                    tile_cursor_q  <= status_snap[1];
                                    tile_locked_q  <= status_snap[2];
                                    tile_clocked_q <= 1'b0;
                                    stat_tile_q    <= 1'b1;
                                    valid_q        <= 1'b1;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end
                            end else begin
                                idx_q   <= idx_q + 6'd1;
                                state_q <= SCAN;
                            end
                        end
                    end
                end
                DONE: begin
                    full_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TileValid        = valid_q;
    assign TileIdx          = tile_idx_q;
    assign TileX            = tile_idx_q[2:0];
    assign TileY            = tile_idx_q[5:3];
    assign TilePiece        = tile_piece_q;
    assign TileWhite        = tile_white_q;
    assign TileCursor       = tile_cursor_q;
    assign TileLocked       = tile_locked_q;
    assign TileCursorLocked = tile_clocked_q;
    assign FrameDone        = done_q;
    assign Busy             = (state_q != IDLE);

endmodule

// File: tb/tb_chess_layout_tile_streamer.sv
// Self-checking bench for chess_layout_tile_streamer: a frame-level model
// predicts the ordered tile list and FrameDone of each frame; one monitor
// checks every handshake and FrameDone pulse against it.
module tb_chess_layout_tile_streamer;

    logic         OutClock;
    logic         resetApp;
    logic [511:0] Layout;
    logic         Player;
    logic [1:0]   Checkmate;
    logic         TileReady;
    logic         TileValid;
    logic [5:0]   TileIdx;
    logic [2:0]   TileX;
    logic [2:0]   TileY;
    logic [2:0]   TilePiece;
    logic         TileWhite;
    logic         TileCursor;
    logic         TileLocked;
    logic         TileCursorLocked;
    logic         FrameDone;
    logic         Busy;

    chess_layout_tile_streamer #(.CHESS_SQUARES(64), .SQUARE_WIDTH(8)) dut (
        .OutClock(OutClock), .resetApp(resetApp), .Layout(Layout),
        .Player(Player), .Checkmate(Checkmate), .TileReady(TileReady),
        .TileValid(TileValid), .TileIdx(TileIdx), .TileX(TileX), .TileY(TileY),
        .TilePiece(TilePiece), .TileWhite(TileWhite), .TileCursor(TileCursor),
        .TileLocked(TileLocked), .TileCursorLocked(TileCursorLocked),
        .FrameDone(FrameDone), .Busy(Busy)
    );

    initial begin
        OutClock = 1'b0;
        forever #5 OutClock = ~OutClock;
    end

`ifdef STATUS_TILE_EN
    localparam int FULL_TILES = 65;
`else
    localparam int FULL_TILES = 64;
`endif

    typedef struct {
        bit         done;
        logic [5:0] idx;
        logic [7:0] b;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] sh_m[64];
    bit         full_m;
    logic [2:0] st_m;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_tiles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] fields();
        return {TileIdx, TileX, TileY, TilePiece, TileWhite, TileCursor, TileLocked, TileCursorLocked};
    endfunction

    function automatic void model_reset();
        full_m = 1'b1;
        st_m   = '0;
        for (int i = 0; i < 64; i++) sh_m[i] = '0;
    endfunction

    // Predict the next frame from the current inputs: changed squares in order, optional status tile, done marker.
    function automatic void commit();
        bit  any;
        ev_t ev;
        any = 0;
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = Layout[i*8 +: 8];
            if (full_m || ((b ^ sh_m[i]) & 8'h7F) != 8'h00) begin
                ev.done = 0; ev.idx = 6'(i); ev.b = b;
                expq.push_back(ev);
                any = 1;
            end
            sh_m[i] = b;
        end
`ifdef STATUS_TILE_EN
        if (full_m || {Checkmate, Player} != st_m) begin
            ev.done = 0; ev.idx = 6'd0; ev.b = {2'b00, Checkmate, Player, 3'd7};
            expq.push_back(ev);
            any = 1;
        end
        st_m = {Checkmate, Player};
`endif
        if (any) begin
            ev.done = 1; ev.idx = '0; ev.b = '0;
            expq.push_back(ev);
        end
        full_m = 1'b0;
    endfunction

    // Monitor: inputs change only just after posedge, so negedge values are those seen at the next edge.
    initial begin
        logic [18:0] held;
        bit          stalled;
        ev_t         ev;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge OutClock);
            if (resetApp) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 32'(TileValid), 32'd1);
                    chk("stall_fields", 32'(fields()), 32'(held));
                end
                if (TileValid && TileReady) begin
                    n_tiles++;
                    if (expq.size() == 0 || expq[0].done) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_tile: got idx %0d piece %0d, required no tile", TileIdx, TilePiece);
                    end else begin
                        ev = expq.pop_front();
                        chk("tile_idx", 32'(TileIdx), 32'(ev.idx));
                        chk("tile_x", 32'(TileX), 32'(ev.idx[2:0]));
                        chk("tile_y", 32'(TileY), 32'(ev.idx[5:3]));
                        chk("tile_bits", 32'({TileCursorLocked, TileLocked, TileCursor, TileWhite, TilePiece}), 32'(ev.b[6:0]));
                    end
                end
                if (FrameDone) begin
                    n_cmp++;
                    if (expq.size() == 0 || !expq[0].done) begin
                        n_err++;
                        $display("FAIL frame_done: got pulse, required %0d more tiles first", expq.size());
                    end else begin
                        void'(expq.pop_front());
                    end
                end
                stalled = TileValid && !TileReady;
                held    = fields();
            end
        end
    end

    // Run until the model queue empties (bounded), optionally randomizing TileReady, then check idle.
    task automatic drain(input bit rnd_ready, input bit check_idle);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(posedge OutClock); #1;
            if (rnd_ready) TileReady = 1'($urandom_range(0, 1));
            n++;
            @(negedge OutClock); #1;
        end
        if (expq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d events pending, required 0", expq.size());
            expq.delete();
        end
        @(posedge OutClock); #1;
        TileReady = 1'b1;
        if (check_idle) begin
            @(negedge OutClock); #1;
            chk("idle_busy", 32'(Busy), 32'd0);
            chk("idle_valid", 32'(TileValid), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, cyc;
        bit          seen, found;
        logic [18:0] held_s;

        resetApp  = 1'b1;
        TileReady = 1'b0;
        Player    = 1'b0;
        Checkmate = 2'b00;
        for (int i = 0; i < 64; i++) Layout[i*8 +: 8] = 8'($urandom);
        Layout[12*8 +: 8] = 8'h00;
        model_reset();

        repeat (3) @(posedge OutClock);
        @(negedge OutClock); #1;
        chk("reset_outputs", 32'({TileValid, fields(), FrameDone, Busy}), 32'd0);

        // First frame after reset: every square in order.
        @(posedge OutClock); #1;
        resetApp  = 1'b0;
        TileReady = 1'b1;
        t0 = n_tiles;
        commit();
        drain(0, 1);
        chk("first_frame_tiles", 32'(n_tiles - t0), 32'(FULL_TILES));

        // Single change: byte 12 00 -> 0B, hand-computed fields and frame latency.
        Layout[12*8 +: 8] = 8'h0B;
        commit();
        cyc = 0; seen = 0;
        while (cyc < 300) begin
            @(posedge OutClock); cyc++;
            @(negedge OutClock); #1;
            if (TileValid && TileReady) begin
                seen = 1;
                chk("b12_idx", 32'(TileIdx), 32'd12);
                chk("b12_x", 32'(TileX), 32'd4);
                chk("b12_y", 32'(TileY), 32'd1);
                chk("b12_piece", 32'(TilePiece), 32'd3);
                chk("b12_white", 32'(TileWhite), 32'd1);
            end
            if (FrameDone) break;
        end
        chk("b12_seen", 32'(seen), 32'd1);
        chk("b12_frame_cycles", 32'(cyc), 32'd66);
        drain(0, 1);

        // Back-pressure: hold TileReady low through three edges of an offer.
        TileReady = 1'b0;
        Layout[20*8 +: 8] = Layout[20*8 +: 8] ^ 8'h12;
        commit();
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge OutClock); #1;
            if (TileValid) found = 1;
        end
        chk("stall_reach", 32'(found), 32'd1);
        held_s = fields();
        repeat (2) begin
            @(posedge OutClock);
            @(negedge OutClock); #1;
            chk("stall_hold_valid", 32'(TileValid), 32'd1);
            chk("stall_hold_fields", 32'(fields()), 32'(held_s));
        end
        @(posedge OutClock); #1;
        TileReady = 1'b1;
        @(negedge OutClock); #1;
        chk("stall_last_valid", 32'(TileValid), 32'd1);
        @(posedge OutClock);
        @(negedge OutClock); #1;
        chk("stall_released", 32'(TileValid), 32'd0);
        drain(0, 1);

        // Snapshot: changes made mid-frame appear only in the following frame.
        Layout[5*8 +: 8]  = Layout[5*8 +: 8] ^ 8'h03;
        Layout[40*8 +: 8] = Layout[40*8 +: 8] ^ 8'h21;
        commit();
        repeat (22) @(posedge OutClock);
        #1;
        Layout[2*8 +: 8]  = Layout[2*8 +: 8] ^ 8'h44;
        Layout[60*8 +: 8] = Layout[60*8 +: 8] ^ 8'h05;
        drain(0, 0);
        commit();
        drain(0, 1);

        // Bit 7 alone never starts a frame.
        Layout[9*8 +: 8] = Layout[9*8 +: 8] ^ 8'h80;
        commit();
        repeat (8) begin
            @(posedge OutClock);
            @(negedge OutClock); #1;
            chk("bit7_busy", 32'(Busy), 32'd0);
        end

        // Asynchronous reset while the tile at index 30 is offered.
        Layout[10*8 +: 8] = Layout[10*8 +: 8] ^ 8'h01;
        Layout[30*8 +: 8] = Layout[30*8 +: 8] ^ 8'h01;
        Layout[50*8 +: 8] = Layout[50*8 +: 8] ^ 8'h01;
        commit();
        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge OutClock); #1;
            if (TileValid && TileIdx == 6'd30) found = 1;
        end
        chk("reach_idx30", 32'(found), 32'd1);
        resetApp = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({TileValid, fields(), FrameDone, Busy}), 32'd0);
        expq.delete();
        model_reset();
        @(posedge OutClock); #1;
        @(posedge OutClock); #1;
        resetApp = 1'b0;
        t0 = n_tiles;
        commit();
        drain(0, 1);
        chk("refresh_after_reset", 32'(n_tiles - t0), 32'(FULL_TILES));

        // Randomized changes with random back-pressure.
        for (int it = 0; it < 25; it++) begin
            int unsigned nchg;
            nchg = $urandom_range(1, 4);
            for (int k = 0; k < int'(nchg); k++) begin
                int unsigned p;
                p = $urandom_range(0, 63);
                Layout[p*8 +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                int unsigned p;
                p = $urandom_range(0, 63);
                Layout[p*8 + 7] = ~Layout[p*8 + 7];
            end
            commit();
            if (expq.size() == 0) begin
                repeat (4) begin
                    @(posedge OutClock);
                    @(negedge OutClock); #1;
                    chk("rand_idle_busy", 32'(Busy), 32'd0);
                end
            end else begin
                drain(1, 1);
            end
        end

`ifdef STATUS_TILE_EN
        // Status-only change: 64 unchanged squares then a status tile.
        Player = ~Player;
        commit();
        drain(0, 1);
        Checkmate = 2'b11;
        commit();
        drain(1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
